// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: hazard cause encoding, forwarding selects and
// the register-match helper used by the stall and forwarding logic.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_REDIRECT   = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // x0 is hardwired zero, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic       wr_en,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
    return wr_en && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// ALU operand bypass select for one execute-stage source register.
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] e_rs,
  input  logic [4:0] m_rd,
  input  logic       m_regwren,
  input  logic [4:0] w_rd,
  input  logic       w_regwren,
  output logic [1:0] fwd
);

  // Memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    fwd = FWD_RF;
    if (reg_match(m_regwren, m_rd, e_rs)) begin
      fwd = FWD_MEM;
    end else if (reg_match(w_regwren, w_rd, e_rs)) begin
      fwd = FWD_WB;
    end else begin
      fwd = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-cycle stall/flush/enable generation, operand
// forwarding, cause history, saturating performance counters and wait timeout.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_uses_rs1,
  input  logic             d_uses_rs2,
  input  logic [4:0]       e_rs1,
  input  logic [4:0]       e_rs2,
  input  logic [4:0]       e_rd,
  input  logic             e_memren,
  input  logic             e_br_taken,
  input  logic [4:0]       m_rd,
  input  logic             m_regwren,
  input  logic [4:0]       w_rd,
  input  logic             w_regwren,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_wren,
  output logic             ifid_wren,
  output logic             idex_wren,
  output logic             exmem_wren,
  output logic             memwb_wren,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT_CYC);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic              mem_wait_s;
  logic              redirect_s;
  logic              load_use_s;
  hz_state_e         cause_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;
  hz_state_e         state_r;
  logic              redir_pend_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              timeout_err_r;

  forward_unit u_fwd_a (
    .e_rs      (e_rs1),
    .m_rd      (m_rd),
    .m_regwren (m_regwren),
    .w_rd      (w_rd),
    .w_regwren (w_regwren),
    .fwd       (fwd_a_s)
  );

  forward_unit u_fwd_b (
    .e_rs      (e_rs2),
    .m_rd      (m_rd),
    .m_regwren (m_regwren),
    .w_rd      (w_rd),
    .w_regwren (w_regwren),
    .fwd       (fwd_b_s)
  );

  // Cause evaluation; a redirect seen while frozen stays pending until the wait ends.
  always_comb begin
    mem_wait_s = dmem_req && !dmem_ready;
    redirect_s = e_br_taken || redir_pend_r;
    load_use_s = e_memren && (e_rd != 5'd0) &&
                 ((d_uses_rs1 && (d_rs1 == e_rd)) || (d_uses_rs2 && (d_rs2 == e_rd)));
    if (mem_wait_s) begin
      cause_s = ST_MEM_WAIT;
    end else if (redirect_s) begin
      cause_s = ST_REDIRECT;
    end else if (load_use_s) begin
      cause_s = ST_LOAD_STALL;
    end else begin
      cause_s = ST_RUN;
    end
  end

  // Zero-latency stage enables, bubbles and forwarding selects.
  always_comb begin
    pc_wren    = 1'b0;
    ifid_wren  = 1'b0;
    idex_wren  = 1'b0;
    exmem_wren = 1'b0;
    memwb_wren = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a      = FWD_RF;
    fwd_b      = FWD_RF;
    if (reset) begin
      pc_wren    = 1'b0;
      idex_flush = 1'b0;
    end else begin
      fwd_a = fwd_a_s;
      fwd_b = fwd_b_s;
      case (cause_s)
        ST_MEM_WAIT: begin
          pc_wren = 1'b0;
        end
        ST_REDIRECT: begin
          {pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren} = 5'b11111;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        ST_LOAD_STALL: begin
          {pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren} = 5'b00111;
          idex_flush = 1'b1;
        end
        ST_RUN: begin
          {pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren} = 5'b11111;
        end
        default: begin
          {pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren} = 5'b00000;
        end
      endcase
    end
  end

  // Cause history, pending redirect and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_RUN;
      redir_pend_r <= 1'b0;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r      <= cause_s;
      redir_pend_r <= mem_wait_s && redirect_s;
      if (((cause_s == ST_LOAD_STALL) || (cause_s == ST_MEM_WAIT)) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if ((cause_s == ST_REDIRECT) && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  // Consecutive memory-wait tracking; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r    <= {WAIT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if (mem_wait_s) begin
      if (wait_cnt_r != WAIT_MAX) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end
      if (wait_cnt_r >= WAIT_LAST) begin
        timeout_err_r <= 1'b1;
      end
    end else begin
      wait_cnt_r <= {WAIT_W{1'b0}};
    end
  end

  assign state       = state_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a table of combinational vectors followed by
// hand-written multi-cycle sequences for counters, waits, timeout and reset.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [4:0]    d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic          d_uses_rs1, d_uses_rs2, e_memren, e_br_taken;
  logic          m_regwren, w_regwren, dmem_req, dmem_ready;
  logic          pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren;
  logic          ifid_flush, idex_flush;
  logic [1:0]    fwd_a, fwd_b, state;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          timeout_err;

  int n_vec  = 0;
  int n_fail = 0;

  hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd), .e_memren(e_memren), .e_br_taken(e_br_taken),
    .m_rd(m_rd), .m_regwren(m_regwren), .w_rd(w_rd), .w_regwren(w_regwren),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_wren(pc_wren), .ifid_wren(ifid_wren), .idex_wren(idex_wren),
    .exmem_wren(exmem_wren), .memwb_wren(memwb_wren),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [4:0] d_rs1, d_rs2;
    logic       du1, du2;
    logic [4:0] e_rs1, e_rs2, e_rd;
    logic       ld, br;
    logic [4:0] m_rd;
    logic       m_wr;
    logic [4:0] w_rd;
    logic       w_wr;
    logic       dreq, drdy;
    logic [4:0] x_wren;
    logic [1:0] x_fl;
    logic [1:0] x_fa, x_fb;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    d_rs1 = v.d_rs1; d_rs2 = v.d_rs2; d_uses_rs1 = v.du1; d_uses_rs2 = v.du2;
    e_rs1 = v.e_rs1; e_rs2 = v.e_rs2; e_rd = v.e_rd; e_memren = v.ld; e_br_taken = v.br;
    m_rd = v.m_rd; m_regwren = v.m_wr; w_rd = v.w_rd; w_regwren = v.w_wr;
    dmem_req = v.dreq; dmem_ready = v.drdy;
  endtask

  function automatic logic [4:0] wren();
    return {pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren};
  endfunction

  vec_t idle_v, lu_v;

  task automatic do_reset();
    reset = 1'b1;
    drive(idle_v);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_v = '0;
    //            rs1    rs2    du1   du2   ers1   ers2   erd    ld    br    mrd    mwr   wrd    wwr   dreq  drdy  wren      fl     fa     fb
    vt[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vt[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00111, 2'b01, 2'b00, 2'b00};
    vt[2]  = '{5'd5, 5'd5, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00111, 2'b01, 2'b00, 2'b00};
    vt[3]  = '{5'd5, 5'd5, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vt[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vt[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11111, 2'b11, 2'b00, 2'b00};
    vt[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b00000, 2'b00, 2'b00, 2'b00};
    vt[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b10, 2'b00};
    vt[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b01, 2'b00};
    vt[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
    vt[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd9, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b10, 2'b01};
    vt[11] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00111, 2'b01, 2'b00, 2'b00};
    vt[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b01};
    lu_v = vt[1];

    // Outputs held inactive while reset is asserted, even with hazards present.
    reset = 1'b1;
    drive(vt[10]);
    e_memren = 1'b1; e_rd = 5'd5; d_rs1 = 5'd5; d_uses_rs1 = 1'b1;
    #1;
    chk("rst_wren", 32'(wren()), 32'h0);
    chk("rst_flush", 32'({ifid_flush, idex_flush}), 32'h0);
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    tick();
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_cnts", 32'({stall_cnt, flush_cnt, timeout_err}), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vt[i]);
      #1;
      chk($sformatf("vec%0d_wren", i), 32'(wren()), 32'(vt[i].x_wren));
      chk($sformatf("vec%0d_flush", i), 32'({ifid_flush, idex_flush}), 32'(vt[i].x_fl));
      chk($sformatf("vec%0d_fwd_a", i), 32'(fwd_a), 32'(vt[i].x_fa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(fwd_b), 32'(vt[i].x_fb));
      tick();
      drive(idle_v);
      tick();
    end

    // Load-use stall registers its cause and counts once.
    do_reset();
    drive(lu_v);
    tick();
    chk("lu_state", 32'(state), 32'h1);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'h1);

    // Redirect outranks load-use.
    do_reset();
    drive(lu_v);
    e_br_taken = 1'b1;
    #1;
    chk("redir_flush", 32'({ifid_flush, idex_flush, pc_wren}), 32'h7);
    tick();
    chk("redir_state", 32'(state), 32'h3);
    chk("redir_cnts", 32'({stall_cnt, flush_cnt}), 32'h01);

    // Branch held through a 3-cycle memory wait, applied once afterwards.
    do_reset();
    drive(idle_v);
    e_br_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw_wren_c%0d", c), 32'({wren(), ifid_flush, idex_flush}), 32'h0);
      tick();
    end
    chk("mw_state", 32'(state), 32'h2);
    dmem_ready = 1'b1;
    #1;
    chk("mw_redir", 32'({wren(), ifid_flush, idex_flush}), 32'h7f);
    tick();
    chk("mw_cnts", 32'({state, stall_cnt, flush_cnt, timeout_err}), 32'({2'd3, 4'd3, 4'd1, 1'b0}));
    drive(idle_v);
    tick();

    // Timeout after exactly four consecutive wait cycles, sticky until reset.
    do_reset();
    drive(idle_v);
    dmem_req = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("to_before", 32'(timeout_err), 32'h0);
    tick();
    chk("to_set", 32'(timeout_err), 32'h1);
    dmem_ready = 1'b1;
    tick();
    tick();
    chk("to_sticky", 32'(timeout_err), 32'h1);
    do_reset();
    chk("to_cleared", 32'(timeout_err), 32'h0);

    // Reset mid-wait abandons the wait; counting restarts from zero.
    drive(idle_v);
    dmem_req = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("rw_wren", 32'(wren()), 32'h0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("rw_no_err", 32'(timeout_err), 32'h0);
    chk("rw_state", 32'(state), 32'h2);
    drive(idle_v);
    tick();

    // Stall counter saturates at all-ones.
    do_reset();
    drive(lu_v);
    for (int c = 0; c < 15; c++) tick();
    chk("sat_15", 32'(stall_cnt), 32'd15);
    for (int c = 0; c < 5; c++) tick();
    chk("sat_20", 32'(stall_cnt), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 256, meaning max consecutive memory-wait cycles before the error flag sets.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the performance counters.
REQ-003 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- d_rs1, d_rs2  in  5 each  decode-stage source register addresses
- d_uses_rs1, d_uses_rs2  in  1 each  decode instruction reads that source
- e_rs1, e_rs2  in  5 each  execute-stage source register addresses
- e_rd  in  5  execute-stage destination
- e_memren  in  1  execute-stage instruction is a load
- e_br_taken  in  1  branch/jump redirect resolved in execute
- m_rd  in  5  memory-stage destination
- m_regwren  in  1  memory-stage register write
- w_rd  in  5  writeback-stage destination
- w_regwren  in  1  writeback-stage register write
- dmem_req  in  1  memory stage has an outstanding data access
- dmem_ready  in  1  data memory completes the access this cycle
- pc_wren, ifid_wren, idex_wren, exmem_wren, memwb_wren  out  1 each  stage write enables
- ifid_flush, idex_flush  out  1 each  bubble insertion
- fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 writeback, 10 memory
- state  out  2  registered cause: 0 RUN, 1 LOAD_STALL, 2 MEM_WAIT, 3 REDIRECT
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters
- timeout_err  out  1  sticky memory-wait timeout

Function
REQ-004 SHALL evaluate the cause each cycle with priority MEM_WAIT > REDIRECT > LOAD_STALL > RUN.
REQ-005 SHALL detect MEM_WAIT when dmem_req=1 and dmem_ready=0, and then drive all five wren=0 and both flushes=0.
REQ-006 SHALL detect REDIRECT when e_br_taken=1 and not MEM_WAIT, and then drive ifid_flush=1, idex_flush=1 and all wren=1.
REQ-007 SHALL detect LOAD_STALL when e_memren=1, e_rd!=0, and (d_uses_rs1 and d_rs1==e_rd, or d_uses_rs2 and d_rs2==e_rd); it SHALL then drive pc_wren=0, ifid_wren=0, idex_flush=1, and all other wren=1.
REQ-008 SHALL, in RUN, drive all wren=1 and both flushes=0.
REQ-009 SHALL drive enables and flushes combinationally in the same cycle as the cause, with zero latency.
REQ-010 SHALL drive fwd_a=10 when m_regwren=1, m_rd!=0 and m_rd==e_rs1; otherwise 01 when w_regwren=1, w_rd!=0 and w_rd==e_rs1; otherwise 00. fwd_b SHALL follow the same rule using e_rs2.
REQ-011 SHALL register the evaluated cause into state on every clock edge, so state shows the previous cycle's cause.
REQ-012 SHALL increment stall_cnt by 1 in each cycle whose cause is LOAD_STALL or MEM_WAIT, and increment flush_cnt by 1 in each REDIRECT cycle.
REQ-013 Both counters SHALL saturate at all-ones and never wrap.
REQ-014 SHALL count consecutive MEM_WAIT cycles and clear the count on any non-MEM_WAIT cycle.
REQ-015 SHALL set timeout_err when the consecutive MEM_WAIT count reaches TIMEOUT_CYC; timeout_err SHALL stay set until reset.
REQ-016 SHALL hold a branch redirect that arrives during MEM_WAIT and apply it in the first cycle after dmem_ready; because EX is frozen, e_br_taken stays asserted.
REQ-017 Register address 0 SHALL never cause a stall or a forward.

Reset
REQ-018 While reset=1, SHALL drive all wren=0, all flushes=0 and fwd_a=fwd_b=00.
REQ-019 On a clock edge with reset=1, SHALL set state=RUN, stall_cnt=0, flush_cnt=0, the wait count to 0 and timeout_err=0.
REQ-020 Reset asserted during MEM_WAIT SHALL abandon the wait and set no error flag.

Structure
REQ-021 Package pipeline_pkg SHALL hold the state enum (RUN/LOAD_STALL/MEM_WAIT/REDIRECT) and the forwarding-select constants (FWD_RF=00, FWD_WB=01, FWD_MEM=10).
REQ-022 Forwarding logic SHALL be a sub-module, forward_unit, instantiated once per operand.

Verification
REQ-023 Load-use: e_memren=1, e_rd=5, d_rs1=5, d_uses_rs1=1 -> pc_wren=0, ifid_wren=0, idex_flush=1; next cycle state=1 and stall_cnt=1.
REQ-024 Redirect beats load-use: e_br_taken=1 with the load-use inputs above -> ifid_flush=idex_flush=1, pc_wren=1; flush_cnt increments by 1.
REQ-025 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles with e_br_taken=1 -> all wren=0 for those 3 cycles, then a redirect in cycle 4; stall_cnt=3, flush_cnt=1.
REQ-026 Forward priority: e_rs1=7, m_rd=7, w_rd=7, both regwren=1 -> fwd_a=10; with m_regwren=0 -> fwd_a=01; with e_rs1=0 -> fwd_a=00.
REQ-027 Timeout: TIMEOUT_CYC=4 and 4 consecutive wait cycles -> timeout_err=1 and it stays 1; after a reset pulse -> timeout_err=0.
REQ-028 Saturation: CNT_W=4 and 20 load-use stall cycles -> stall_cnt=15.
